// File: rtl/syn_lb_host_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : syn_lb_host_ctrl_if
// Brief    : Host command/response port and local-bus port bundle for the
//            LB host controller. "master" is the controller view, "slave"
//            is the host + LB environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface syn_lb_host_ctrl_if #(
  parameter int P_LB_DATA_W = 32,
  parameter int P_LB_ADDR_W = 12
);
  // Host command port
  logic                   host_req_valid;
  logic                   host_req_ready;
  logic                   host_req_wr;
  logic [P_LB_ADDR_W-1:0] host_req_addr;
  logic [P_LB_DATA_W-1:0] host_req_wdata;
  // Host response port
  logic                   host_rsp_valid;
  logic [P_LB_DATA_W-1:0] host_rsp_rdata;
  logic                   host_rsp_err;
  // Local bus
  logic                   lb_rd_en;
  logic                   lb_wr_en;
  logic [P_LB_ADDR_W-1:0] lb_addr;
  logic [P_LB_DATA_W-1:0] lb_wr_data;
  logic                   lb_rd_valid;
  logic                   lb_wr_valid;
  logic [P_LB_DATA_W-1:0] lb_rd_data;

  modport master (
    input  host_req_valid, host_req_wr, host_req_addr, host_req_wdata,
    output host_req_ready,
    output host_rsp_valid, host_rsp_rdata, host_rsp_err,
    output lb_rd_en, lb_wr_en, lb_addr, lb_wr_data,
    input  lb_rd_valid, lb_wr_valid, lb_rd_data
  );

  modport slave (
    output host_req_valid, host_req_wr, host_req_addr, host_req_wdata,
    input  host_req_ready,
    input  host_rsp_valid, host_rsp_rdata, host_rsp_err,
    input  lb_rd_en, lb_wr_en, lb_addr, lb_wr_data,
    output lb_rd_valid, lb_wr_valid, lb_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/syn_lb_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : syn_lb_host_ctrl
// Brief    : Single-outstanding local-bus transaction master. Accepts one
//            host read/write command, issues a one-cycle LB strobe, waits for
//            the matching completion or a timeout, and returns one response.
// Revision : 1.0 - initial release
// ============================================================================
module syn_lb_host_ctrl #(
  parameter int P_LB_DATA_W  = 32,
  parameter int P_LB_ADDR_W  = 12,
  parameter int P_TMO_W      = 8,
  parameter int P_TMO_CYCLES = 200
) (
  input  wire logic              clk_ir,
  input  wire logic              rst_sync,
  syn_lb_host_ctrl_if.master     bus,
  output logic [7:0]             tmo_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter value at which the transaction gives up
  localparam logic [P_TMO_W-1:0] C_TMO_LAST = P_TMO_W'(P_TMO_CYCLES - 1);

  state_t             state;
  logic               is_wr;
  logic [P_TMO_W-1:0] cnt;
  logic               match;
  logic               at_limit;

  // Only the completion type that matches the outstanding command counts
  assign match    = is_wr ? bus.lb_wr_valid : bus.lb_rd_valid;
  assign at_limit = (cnt == C_TMO_LAST);

  // Ready is the only combinational output: idle and not held in reset
  assign bus.host_req_ready = (state == IDLE) && !rst_sync;

  // Transaction sequencer with registered strobes and response
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      state              <= IDLE;
      is_wr              <= 1'b0;
      cnt                <= '0;
      tmo_cnt            <= 8'd0;
      bus.lb_rd_en       <= 1'b0;
      bus.lb_wr_en       <= 1'b0;
      bus.lb_addr        <= '0;
      bus.lb_wr_data     <= '0;
      bus.host_rsp_valid <= 1'b0;
      bus.host_rsp_rdata <= '0;
      bus.host_rsp_err   <= 1'b0;
    end else begin
      // Strobes and response valid are single-cycle pulses by default
      bus.lb_rd_en       <= 1'b0;
      bus.lb_wr_en       <= 1'b0;
      bus.host_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.host_req_valid) begin
            is_wr          <= bus.host_req_wr;
            bus.lb_addr    <= bus.host_req_addr;
            bus.lb_wr_data <= bus.host_req_wdata;
            bus.lb_wr_en   <= bus.host_req_wr;
            bus.lb_rd_en   <= !bus.host_req_wr;
            cnt            <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          // A completion on the timeout cycle still counts as success
          if (match) begin
            bus.host_rsp_valid <= 1'b1;
            bus.host_rsp_err   <= 1'b0;
            bus.host_rsp_rdata <= is_wr ? '0 : bus.lb_rd_data;
            state              <= RESP;
          end else if (at_limit) begin
            bus.host_rsp_valid <= 1'b1;
            bus.host_rsp_err   <= 1'b1;
            bus.host_rsp_rdata <= '0;
            if (tmo_cnt != 8'hFF) begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
            state <= RESP;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= WAIT;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_syn_lb_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_syn_lb_host_ctrl
// Brief    : Self-checking bench for syn_lb_host_ctrl: vector table of
//            commands with a slave model and a response scoreboard, plus
//            back-to-back, reset-abort and timeout-saturation sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_syn_lb_host_ctrl;

  localparam int P_TMO = 4;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          lat;       // strobe-to-valid delay, -1 = slave never answers
    logic [31:0] rdata;     // data the slave drives on lb_rd_data
    logic        stray;     // drive the non-matching valid one cycle after strobe
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tmo_cnt;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_rsp = 0;
  int   n_rd_str = 0;
  int   n_wr_str = 0;
  int   tmo_exp = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[7];

  syn_lb_host_ctrl_if #(.P_LB_DATA_W(32), .P_LB_ADDR_W(12)) bus ();

  syn_lb_host_ctrl #(
    .P_LB_DATA_W (32),
    .P_LB_ADDR_W (12),
    .P_TMO_W     (8),
    .P_TMO_CYCLES(P_TMO)
  ) dut (
    .clk_ir  (clk),
    .rst_sync(rst),
    .bus     (bus),
    .tmo_cnt (tmo_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus.lb_rd_en === 1'b1) n_rd_str++;
    if (bus.lb_wr_en === 1'b1) n_wr_str++;
    if (bus.host_rsp_valid === 1'b1) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'(bus.host_rsp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", 64'(bus.host_rsp_rdata), 64'(mon_e.rdata));
        chk("rsp_err",   64'(bus.host_rsp_err),   64'(mon_e.err));
        chk("rsp_cycle", 64'(cyc),                64'(mon_e.cyc));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},     64'(bus.host_req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.host_rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(bus.host_rsp_rdata), 64'd0);
    chk({tag, "_rsp_err"},   64'(bus.host_rsp_err),   64'd0);
    chk({tag, "_rd_en"},     64'(bus.lb_rd_en),       64'd0);
    chk({tag, "_wr_en"},     64'(bus.lb_wr_en),       64'd0);
    chk({tag, "_lb_addr"},   64'(bus.lb_addr),        64'd0);
    chk({tag, "_lb_wdata"},  64'(bus.lb_wr_data),     64'd0);
    chk({tag, "_tmo_cnt"},   64'(tmo_cnt),            64'd0);
  endtask

  // One complete command: host drive, slave model, scoreboard push, checks
  task automatic run_cmd(input vec_t v);
    int   n;
    int   a;
    int   last;
    int   sr0;
    int   sw0;
    exp_t e;
    sr0 = n_rd_str;
    sw0 = n_wr_str;
    @(negedge clk);
    bus.host_req_valid = 1'b1;
    bus.host_req_wr    = v.wr;
    bus.host_req_addr  = v.addr;
    bus.host_req_wdata = v.wdata;
    n = 0;
    while (bus.host_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 64'(bus.host_req_ready), 64'd1);
      bus.host_req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.host_req_valid = 1'b0;
    bus.host_req_addr  = ~v.addr;
    bus.host_req_wdata = ~v.wdata;
    a       = cyc;
    last    = (v.lat >= 0) ? v.lat : P_TMO - 1;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.cyc   = a + 1 + last;
    sb.push_back(e);
    chk("strobe_wr_en", 64'(bus.lb_wr_en), 64'(v.wr));
    chk("strobe_rd_en", 64'(bus.lb_rd_en), 64'(!v.wr));
    for (int j = 0; j <= last; j++) begin
      if (j > 0) @(negedge clk);
      bus.lb_rd_data  = v.rdata;
      bus.lb_rd_valid = !v.wr ? (j == v.lat) : (v.stray && j == 1);
      bus.lb_wr_valid =  v.wr ? (j == v.lat) : (v.stray && j == 1);
      chk("busy_ready", 64'(bus.host_req_ready), 64'd0);
      chk("lb_addr",    64'(bus.lb_addr),        64'(v.addr));
      chk("lb_wr_data", 64'(bus.lb_wr_data),     64'(v.wdata));
    end
    @(negedge clk);
    bus.lb_rd_valid = 1'b0;
    bus.lb_wr_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < P_TMO + 10) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_missing", 64'(sb.size()), 64'd0);
    sb.delete();
    chk("wr_strobe_count", 64'(n_wr_str - sw0), 64'(v.wr ? 1 : 0));
    chk("rd_strobe_count", 64'(n_rd_str - sr0), 64'(v.wr ? 0 : 1));
    if (v.exp_err) tmo_exp = (tmo_exp == 255) ? 255 : tmo_exp + 1;
    chk("tmo_cnt", 64'(tmo_cnt), 64'(tmo_exp));
  endtask

  initial begin
    int   acc[3];
    int   nacc;
    int   rsp0;
    exp_t e;
    vec_t tv;

    //          wr    addr     wdata          lat rdata          stray exp_rdata      err
    vecs[0] = '{1'b1, 12'h102, 32'hA5A5_0001,  2, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 12'h305, 32'h0000_0000,  0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 12'h0AA, 32'h0000_0000, -1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 12'h210, 32'h0000_0000,  3, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 12'hFFF, 32'hFFFF_FFFF,  1, 32'h5555_AAAA, 1'b1, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b1, 12'h7E1, 32'h1357_9BDF, -1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 12'h800, 32'h0000_0000,  1, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0};

    bus.host_req_valid = 1'b0;
    bus.host_req_wr    = 1'b0;
    bus.host_req_addr  = '0;
    bus.host_req_wdata = '0;
    bus.lb_rd_valid    = 1'b0;
    bus.lb_wr_valid    = 1'b0;
    bus.lb_rd_data     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    rst = 1'b0;
    #1;
    chk("init_ready_after_rst", 64'(bus.host_req_ready), 64'd1);

    // Table-driven commands
    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Back-to-back zero-latency reads: accepts every 3 cycles
    nacc = 0;
    @(negedge clk);
    bus.host_req_valid = 1'b1;
    bus.host_req_wr    = 1'b0;
    bus.host_req_addr  = 12'h305;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      bus.lb_rd_valid = bus.lb_rd_en;
      bus.lb_rd_data  = 32'h1111_0000 + 32'(i);
      if (bus.lb_rd_en === 1'b1) begin
        e.rdata = 32'h1111_0000 + 32'(i);
        e.err   = 1'b0;
        e.cyc   = cyc + 1;
        sb.push_back(e);
      end
      if (bus.host_req_ready === 1'b1 && bus.host_req_valid && nacc < 3) begin
        acc[nacc] = cyc;
        nacc++;
      end else if (nacc == 3) begin
        bus.host_req_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.lb_rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_accepts", 64'(nacc), 64'd3);
    chk("b2b_period_0", 64'(acc[1] - acc[0]), 64'd3);
    chk("b2b_period_1", 64'(acc[2] - acc[1]), 64'd3);
    chk("b2b_rsp_left", 64'(sb.size()), 64'd0);
    sb.delete();

    // Reset during WAIT of a write aborts it with no response
    rsp0 = n_rsp;
    @(negedge clk);
    bus.host_req_valid = 1'b1;
    bus.host_req_wr    = 1'b1;
    bus.host_req_addr  = 12'h4C3;
    bus.host_req_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.host_req_valid = 1'b0;
    chk("rst_seq_strobe", 64'(bus.lb_wr_en), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    tmo_exp = 0;
    @(negedge clk);
    bus.lb_wr_valid = 1'b1;
    @(negedge clk);
    bus.lb_wr_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_no_rsp", 64'(n_rsp - rsp0), 64'd0);
    run_cmd(vecs[0]);

    // Back-to-back timeouts saturate the timeout counter
    tv = vecs[5];
    for (int i = 0; i < 300; i++) begin
      tv.addr  = 12'(i);
      tv.stray = i[0];
      run_cmd(tv);
    end
    chk("tmo_saturated", 64'(tmo_cnt), 64'd255);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/syn_lb_host_ctrl.md
# syn_lb_host_ctrl

Local-bus transaction master that sits directly upstream of the ACORTEX LB address decoder. It accepts single read/write commands from a host-side command port (UART/JTAG bridge), drives one-cycle `rd_en`/`wr_en` strobes with stable address and data onto the 12-bit-address LB, and waits for the matching `rd_valid`/`wr_valid`. It returns exactly one response per command, and flags an error if no valid arrives within a programmable timeout. It guarantees one outstanding LB transaction at a time, which the downstream decoder and sub-blocks rely on.

## Interface
- `P_LB_DATA_W`, 32, LB data width
- `P_LB_ADDR_W`, 12, LB address width; upper 4 bits are the decoder block code
- `P_TMO_W`, 8, timeout counter width
- `P_TMO_CYCLES`, 200, cycles waited for a valid before timeout; legal range 1..2^P_TMO_W-1
- `clk_ir`  in  1  clock (single clock domain)
- `rst_sync`  in  1  reset, synchronous, active-high
- `host_req_valid`  in  1  command valid
- `host_req_ready`  out  1  command accepted when valid&ready
- `host_req_wr`  in  1  1=write, 0=read
- `host_req_addr`  in  P_LB_ADDR_W  command address
- `host_req_wdata`  in  P_LB_DATA_W  write data
- `host_rsp_valid`  out  1  one-cycle response pulse
- `host_rsp_rdata`  out  P_LB_DATA_W  read data; 0 for writes and timeouts
- `host_rsp_err`  out  1  1=timeout, qualified by host_rsp_valid
- `lb_rd_en`, `lb_wr_en`  out  1  one-cycle LB strobes
- `lb_addr`  out  P_LB_ADDR_W  LB address
- `lb_wr_data`  out  P_LB_DATA_W  LB write data
- `lb_rd_valid`, `lb_wr_valid`  in  1  LB completions
- `lb_rd_data`  in  P_LB_DATA_W  LB read data, sampled when lb_rd_valid=1
- `tmo_cnt`  out  8  saturating count of timed-out transactions

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered except `host_req_ready`, which is high exactly when state=IDLE and rst_sync=0.
- IDLE: on valid&ready, latch wr, addr and wdata into `lb_addr`/`lb_wr_data`. Next state is ISSUE.
- ISSUE: assert `lb_wr_en` (write) or `lb_rd_en` (read) for exactly one cycle. The timeout counter is 0. Next state is WAIT unless a matching valid is seen this cycle, in which case go to RESP.
- WAIT: strobes stay low. `lb_addr`/`lb_wr_data` are held. The counter increments each cycle.
- Matching completion: `lb_rd_valid` for a read, `lb_wr_valid` for a write. On a matching completion, go to RESP with err=0. For a read, capture `lb_rd_data`; for a write, rdata=0.
- Non-matching valids (e.g. wr_valid during a read) are ignored in every state. Any valid in IDLE or RESP is ignored.
- Timeout: if the counter equals P_TMO_CYCLES-1 and no matching valid is present, go to RESP with err=1 and rdata=0. `tmo_cnt` increments, saturating at 255.
- A matching valid that arrives in the same cycle as the timeout condition takes priority: success, err=0.
- RESP: `host_rsp_valid`=1 for one cycle, then IDLE.
- `lb_addr`/`lb_wr_data` keep their last values after a transaction. They change only on acceptance of a new command.

## Timing
- Reset values: state=IDLE, host_req_ready=0 while rst_sync=1, host_rsp_valid=0, host_rsp_rdata=0, host_rsp_err=0, lb_rd_en=0, lb_wr_en=0, lb_addr=0, lb_wr_data=0, tmo_cnt=0, counter=0.
- Command accepted at cycle T: strobe at T+1. A matching valid at T+1+k (k≥0) gives host_rsp_valid at T+2+k. The next accept is possible at T+3+k.
- Timeout with no valid: host_rsp_valid at T+1+P_TMO_CYCLES. Minimum command period is 3 cycles (zero-latency slave).
- Reset asserted mid-transaction: the transaction is aborted with no response. Strobes and rsp_valid are 0 in the cycle after rst_sync is sampled high. An LB valid arriving after reset is ignored.
- host_req_* is don't-care when ready=0. The host holds the command until accepted.

## Test plan
- Write addr 0x102, data 0xA5A5_0001; slave asserts wr_valid 2 cycles after the strobe -> exactly one lb_wr_en pulse with lb_addr=0x102; rsp_valid with err=0 and rdata=0, 3 cycles after the strobe.
- Read addr 0x305; slave asserts rd_valid with 0x1234_5678 in the same cycle as lb_rd_en -> rsp_valid next cycle, rdata=0x1234_5678; next command accepted 3 cycles after the first.
- Read with P_TMO_CYCLES=4 and no slave response; a stray wr_valid during WAIT -> wr_valid ignored; rsp_valid 5 cycles after accept with err=1, rdata=0; tmo_cnt=1.
- With P_TMO_CYCLES=4, rd_valid arrives exactly at counter=3 -> err=0 and data captured; tmo_cnt unchanged.
- Assert rst_sync for 1 cycle during WAIT of a write -> no rsp_valid; all outputs return to reset values; a late wr_valid produces no response; a new command completes normally.
- 300 back-to-back timed-out commands -> tmo_cnt saturates at 255.
